// File: rtl/servo_pkg.sv
// Shared types and default constants for the servo PWM generator.
package servo_pkg;

  localparam int unsigned WIDTH_W = 20;

  typedef logic [WIDTH_W-1:0] width_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Defaults assume a 50 MHz clock: 20 ms frame, 1.0 / 1.5 / 2.0 ms pulses.
  localparam int unsigned DEF_PERIOD_CYC = 1000000;
  localparam int unsigned DEF_MIN_CYC    = 50000;
  localparam int unsigned DEF_MAX_CYC    = 100000;
  localparam int unsigned DEF_CENTER_CYC = 75000;
  localparam int unsigned DEF_SLEW_STEP  = 500;

  // Saturate a commanded width into the legal [lo, hi] window.
  function automatic width_t clamp_width(input width_t w, input width_t lo, input width_t hi);
    if (w < lo) return lo;
    if (w > hi) return hi;
    return w;
  endfunction

endpackage

// File: rtl/servo_slew_limiter.sv
// Clamps the commanded pulse width into [MIN_CYC, MAX_CYC] and holds the width
// applied to the current frame. Defining SERVO_SLEW_EN adds a per-frame step
// limit of SLEW_STEP cycles; without it the clamped target is applied directly.
module servo_slew_limiter
  import servo_pkg::*;
#(
  parameter int unsigned MIN_CYC    = DEF_MIN_CYC,
  parameter int unsigned MAX_CYC    = DEF_MAX_CYC,
  parameter int unsigned CENTER_CYC = DEF_CENTER_CYC,
  parameter int unsigned SLEW_STEP  = DEF_SLEW_STEP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               latch_en,
  input  logic [WIDTH_W-1:0] width_cmd,
  output logic [WIDTH_W-1:0] width_act,
  output logic               clamped
);

  localparam width_t MIN_W    = width_t'(MIN_CYC);
  localparam width_t MAX_W    = width_t'(MAX_CYC);
  localparam width_t CENTER_W = width_t'(CENTER_CYC);

  if (MIN_CYC > CENTER_CYC || CENTER_CYC > MAX_CYC || SLEW_STEP == 0) begin : g_bad_cfg
    $error("servo_slew_limiter: need MIN_CYC <= CENTER_CYC <= MAX_CYC and SLEW_STEP > 0");
  end

  width_t target;
  width_t width_next;
  logic   out_of_range;

  assign out_of_range = (width_cmd < MIN_W) || (width_cmd > MAX_W);
  assign target       = clamp_width(width_cmd, MIN_W, MAX_W);

`ifdef SERVO_SLEW_EN
  localparam width_t STEP_W = width_t'(SLEW_STEP);

  // Move toward the target by at most one step; land exactly when close enough.
  // Both endpoints are inside the legal window, so the result is too.
  always_comb begin
    width_next = target;
    if (target > width_act && (target - width_act) > STEP_W) begin
      width_next = width_act + STEP_W;
    end else if (target < width_act && (width_act - target) > STEP_W) begin
      width_next = width_act - STEP_W;
    end
  end
`else
  assign width_next = target;
`endif

  // Capture the new width and the clamp flag only at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_act <= CENTER_W;
      clamped   <= 1'b0;
    end else if (latch_en) begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples pre-edge values regardless of statement order.
      width_act <= width_next;
      clamped   <= out_of_range;
    end
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// Servo PWM frame generator: one PERIOD_CYC-cycle frame per period, pulse high
// for width_act_o cycles at the start of each frame, width latched only at
// frame boundaries. Optional slew limiting is enabled by defining SERVO_SLEW_EN.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC,
  parameter int unsigned MIN_CYC    = DEF_MIN_CYC,
  parameter int unsigned MAX_CYC    = DEF_MAX_CYC,
  parameter int unsigned CENTER_CYC = DEF_CENTER_CYC,
  parameter int unsigned SLEW_STEP  = DEF_SLEW_STEP
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic [WIDTH_W-1:0] width_i,
  input  logic               enable_i,
  output logic               pwm_o,
  output logic               frame_o,
  output logic [WIDTH_W-1:0] width_act_o,
  output logic               clamped_o
);

  if (PERIOD_CYC > (1 << WIDTH_W) || PERIOD_CYC <= MAX_CYC) begin : g_bad_period
    $error("servo_pwm_gen: PERIOD_CYC must be <= 2**20 and > MAX_CYC");
  end

  localparam width_t PERIOD_LAST = width_t'(PERIOD_CYC - 1);
  localparam width_t ONE         = width_t'(1);

  state_t state_q, state_d;
  width_t cnt_q, cnt_d;
  logic   latch_en;
  logic   frame_d;

  servo_slew_limiter #(
    .MIN_CYC   (MIN_CYC),
    .MAX_CYC   (MAX_CYC),
    .CENTER_CYC(CENTER_CYC),
    .SLEW_STEP (SLEW_STEP)
  ) u_limiter (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .latch_en (latch_en),
    .width_cmd(width_i),
    .width_act(width_act_o),
    .clamped  (clamped_o)
  );

  // Next-state, counter and frame-start decode for the IDLE/HIGH/LOW machine.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    frame_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          cnt_d    = '0;
          latch_en = 1'b1;
          frame_d  = 1'b1;
          state_d  = HIGH;
        end
      end
      HIGH: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == width_act_o - ONE) state_d = LOW;
      end
      LOW: begin
        if (cnt_q == PERIOD_LAST) begin
          // Frame boundary: wrap and either chain the next frame or stop.
          cnt_d = '0;
          if (enable_i) begin
            latch_en = 1'b1;
            frame_d  = 1'b1;
            state_d  = HIGH;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs; reset drops pwm_o at once.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pwm_o   <= 1'b0;
      frame_o <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwm_o   <= (state_d == HIGH);
      frame_o <= frame_d;
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Scoreboard bench for servo_pwm_gen with a scaled-down frame (200 cycles,
// widths 50/75/100, step 5) so each frame is short. The stimulus pushes the
// expected per-frame record; the monitor measures every frame on the pins and
// pops/compares when the frame ends.
module tb_servo_pwm_gen;
  import servo_pkg::*;

  localparam int unsigned P    = 200;
  localparam int unsigned MINC = 50;
  localparam int unsigned MAXC = 100;
  localparam int unsigned CEN  = 75;
  localparam int unsigned STEP = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [19:0] width = '0;
  logic        pwm;
  logic        frame;
  logic [19:0] width_act;
  logic        clamped;

  servo_pwm_gen #(
    .PERIOD_CYC(P),
    .MIN_CYC   (MINC),
    .MAX_CYC   (MAXC),
    .CENTER_CYC(CEN),
    .SLEW_STEP (STEP)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .width_i      (width),
    .enable_i     (enable),
    .pwm_o        (pwm),
    .frame_o      (frame),
    .width_act_o  (width_act),
    .clamped_o    (clamped)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int width;
    int clamped;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int w, input int c);
    exp_t e;
    e.width   = w;
    e.clamped = c;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  bit in_frame     = 1'b0;
  bit pwm_idle_err = 1'b0;
  int len, hi, cap_w, cap_c;

  task automatic finalize();
    exp_t e;
    check("expected_frame_pending", int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("width_act", cap_w, e.width);
      check("clamped", cap_c, e.clamped);
      check("high_len", hi, e.width);
      check("frame_len", len, int'(P));
    end
    in_frame = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (in_frame && (frame || dut.state_q == IDLE)) finalize();
      if (frame) begin
        in_frame = 1'b1;
        len      = 0;
        hi       = 0;
        cap_w    = int'(width_act);
        cap_c    = int'(clamped);
      end
      if (in_frame) begin
        len++;
        if (pwm) hi++;
      end else if (pwm) begin
        pwm_idle_err = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_strobe(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame && n < int'(2 * P));
    check(tag, int'(frame), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dut.state_q != IDLE && n < int'(2 * P));
    check(tag, int'(dut.state_q), int'(IDLE));
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    width = 20'd60;
    repeat (3) @(negedge clk);
    check("reset_pwm", int'(pwm), 0);
    check("reset_frame", int'(frame), 0);
    check("reset_width_act", int'(width_act), 75);
    check("reset_clamped", int'(clamped), 0);
    check("reset_state", int'(dut.state_q), int'(IDLE));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_frame", int'(frame), 0);

`ifndef SERVO_SLEW_EN
    // Basic 60-cycle frame, then mid-frame change to 90 at cycle 30.
    push_exp(60, 0);
    enable = 1'b1;
    wait_strobe("strobe_first");
    repeat (30) @(negedge clk);
    width = 20'd90;
    push_exp(90, 0);
    wait_strobe("strobe_90");
    // Below-range and above-range commands are clamped.
    repeat (40) @(negedge clk);
    width = 20'd20;
    push_exp(50, 1);
    wait_strobe("strobe_lo");
    repeat (40) @(negedge clk);
    width = 20'd150;
    push_exp(100, 1);
    wait_strobe("strobe_hi");
    repeat (40) @(negedge clk);
    width = 20'd60;
    push_exp(60, 0);
    wait_strobe("strobe_60");
    // Change on the boundary cycle itself is taken; a change one cycle later is not.
    repeat (P - 1) @(negedge clk);
    width = 20'd80;
    push_exp(80, 0);
    @(negedge clk);
    check("strobe_after_boundary", int'(frame), 1);
    width = 20'd95;
    push_exp(95, 0);
    wait_strobe("strobe_95");
`else
    // Slewed approach from 75 to 97 in steps of 5, last step exact.
    width = 20'd97;
    push_exp(80, 0);
    push_exp(85, 0);
    push_exp(90, 0);
    push_exp(95, 0);
    push_exp(97, 0);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) wait_strobe("strobe_slew");
`endif

    // Drop enable at cycle 10: frame completes, then idle with pwm low.
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_idle("idle_after_disable");
    repeat (2 * P) @(negedge clk);
    check("frames_outstanding", exp_q.size(), 0);
    check("pwm_low_when_idle", int'(pwm_idle_err), 0);

    // Reset in the middle of a clamped 100-cycle pulse; this frame is aborted.
    width  = 20'd120;
    enable = 1'b1;
    wait_strobe("strobe_pre_reset");
    repeat (40) @(negedge clk);
    check("pwm_high_before_reset", int'(pwm), 1);
    check("clamped_before_reset", int'(clamped), 1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_pwm", int'(pwm), 0);
    check("reset_mid_width_act", int'(width_act), 75);
    check("reset_mid_clamped", int'(clamped), 0);
    check("reset_mid_frame", int'(frame), 0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_state", int'(dut.state_q), int'(IDLE));
    check("post_reset_pwm", int'(pwm), 0);

    // Resume cleanly from IDLE with a full frame.
    width = 20'd70;
    push_exp(70, 0);
    enable = 1'b1;
    wait_strobe("strobe_resume");
    repeat (20) @(negedge clk);
    enable = 1'b0;
    wait_idle("idle_final");
    repeat (P) @(negedge clk);
    check("frames_outstanding_final", exp_q.size(), 0);
    check("pwm_low_when_idle_final", int'(pwm_idle_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/servo_pwm_gen.md
SERVO_PWM_GEN -- requirements
Module: servo_pwm_gen

Interface
REQ-001 The block SHALL have parameter PERIOD_CYC, default 1000000, meaning frame length in clk_clk cycles (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter MIN_CYC, default 50000, meaning the minimum legal pulse width (1.0 ms).
REQ-003 The block SHALL have parameter MAX_CYC, default 100000, meaning the maximum legal pulse width (2.0 ms).
REQ-004 The block SHALL have parameter CENTER_CYC, default 75000, meaning the reset and neutral pulse width (1.5 ms).
REQ-005 The block SHALL have parameter SLEW_STEP, default 500, meaning the maximum width change per frame when slew limiting is compiled in.
REQ-006 The block SHALL have port clk_clk  input  1  system clock; all logic runs in this single clock domain.
REQ-007 The block SHALL have port reset_reset_n  input  1  asynchronous active-low reset.
REQ-008 The block SHALL have port width_i  input  20  commanded pulse width in clk_clk cycles, driven by the memory-mapped register output (custom_leds_0_leds_new_signal).
REQ-009 The block SHALL have port enable_i  input  1  when 1, the block generates frames.
REQ-010 The block SHALL have port pwm_o  output  1  servo pulse output.
REQ-011 The block SHALL have port frame_o  output  1  one-cycle strobe on the first cycle of every frame.
REQ-012 The block SHALL have port width_act_o  output  20  pulse width applied in the current frame.
REQ-013 The block SHALL have port clamped_o  output  1  set when the last latched width_i was outside [MIN_CYC, MAX_CYC].

Function
REQ-014 The FSM SHALL have the states IDLE, HIGH and LOW.
REQ-015 In IDLE with enable_i=1, the FSM SHALL load the frame counter with 0, latch the width, pulse frame_o, and enter HIGH on the next cycle.
REQ-016 In HIGH, pwm_o SHALL be 1; when the counter reaches width_act_o-1, the FSM SHALL go to LOW.
REQ-017 In LOW, pwm_o SHALL be 0; at counter=PERIOD_CYC-1, the FSM SHALL wrap the counter to 0 and either start a new frame (enable_i=1, latch, frame_o, HIGH) or return to IDLE (enable_i=0).
REQ-018 The high time SHALL be exactly width_act_o cycles, and the frame SHALL be exactly PERIOD_CYC cycles, with no gap between consecutive frames.
REQ-019 Width latch: target = min(max(width_i, MIN_CYC), MAX_CYC), and clamped_o SHALL be updated at the same edge.
REQ-020 Changes to width_i mid-frame SHALL be ignored until the next frame boundary, so no glitches or runt pulses occur.
REQ-021 When enable_i is deasserted mid-frame, the current frame SHALL complete in full; IDLE is entered only at the frame end.
REQ-022 When enable_i=1 and width_i changes on the boundary cycle itself, the value present on that cycle SHALL be latched.
REQ-023 The counter SHALL be 20 bits wide, and its comparisons SHALL be unsigned; PERIOD_CYC SHALL be at most 2^20 and strictly greater than MAX_CYC (elaboration-time assertion).

Reset
REQ-024 On reset_reset_n=0, the block SHALL asynchronously set the state to IDLE, the counter to 0, pwm_o to 0, frame_o to 0, width_act_o to CENTER_CYC, and clamped_o to 0.
REQ-025 Reset assertion mid-pulse SHALL drop pwm_o immediately, and release SHALL resume from IDLE with no partial frame.

Configuration
REQ-026 With SERVO_SLEW_EN defined, each latch SHALL move width_act_o toward the clamped target by at most SLEW_STEP (exact hit when the distance is at most SLEW_STEP), and the result SHALL never leave [MIN_CYC, MAX_CYC].
REQ-027 Without SERVO_SLEW_EN, width_act_o SHALL take the clamped target directly at each latch, and no slew logic SHALL be synthesized.

Structure
REQ-028 Package servo_pkg SHALL hold the 20-bit width typedef, the FSM state enum, and the default period/min/max/center/step constants.
REQ-029 One sub-module, servo_slew_limiter (clamp plus optional step limit, combinational with registered output enable), SHALL be instantiated by servo_pwm_gen.

Verification
REQ-030 Verification SHALL cover: reset release, enable_i=1, width_i=60000 -> frame_o strobe, pwm_o high for exactly 60000 cycles, frame length exactly 1000000 cycles.
REQ-031 Verification SHALL cover: width_i=20000, then 150000 -> width_act_o=50000 then 100000, with clamped_o=1 for both.
REQ-032 Verification SHALL cover: width_i changed from 60000 to 90000 at cycle 30000 of a frame -> current pulse stays 60000 cycles, and the next frame is 90000 cycles (SLEW off).
REQ-033 Verification SHALL cover: enable_i dropped at cycle 10 of a frame -> the frame completes, pwm_o stays 0 afterwards, and the state is IDLE.
REQ-034 Verification SHALL cover: with SERVO_SLEW_EN, width_i stepped from 75000 to 77200 -> successive frames 75500, 76000, 76500, 77000, 77200.
REQ-035 Verification SHALL cover: reset asserted at cycle 20000 of a pulse -> pwm_o=0 immediately and width_act_o=75000.
